// File: rtl/seq_controller.sv
// -----------------------------------------------------------------------------
// seq_controller
//
// Multi-phase sequencing controller for the accumulator CPU. Steps an 8-phase
// instruction cycle, latches the opcode once per instruction, stalls on a
// memory-ready handshake, holds a sticky halt, flags illegal opcodes and drives
// every datapath strobe (PC, IR, accumulator, ALU, memory).
//
// Parameters
//   OPCODE_W    opcode width (>= 3); bits above [2:0] must be zero when legal
//   ALU_OP_W    ALU_OP width (>= 2); encoding in [1:0], upper bits zero
//   MEM_WAIT_EN 1 = honour mem_ready, 0 = treat mem_ready as always 1
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   opcode     in   opcode field from the IR
//   zero       in   accumulator-is-zero flag (used in phase 6 only)
//   mem_ready  in   memory has completed the current read
//   phase      out  current phase 0..7 (also the FSM state for observation)
//   addrSel    out  1 = PC drives the memory address, 0 = IR operand
//   memRead    out  memory read strobe
//   memWrite   out  memory write strobe
//   loadIR     out  IR load
//   incPC      out  PC increment
//   jump       out  PC load from the operand
//   ACCwrite   out  accumulator write
//   ALUToACC   out  1 = ALU result into ACC, 0 = memory data
//   ALU_OP     out  00 ADD, 01 AND, 10 XOR, 11 pass (phases 5..7 only)
//   dataEn     out  accumulator drives the data bus
//   skip       out  skip taken
//   Halt       out  sticky halt
//   illegal    out  illegal-opcode flag for the current instruction
//
// Handshake: mem_ready is a level, sampled on the rising edge. In phase 1,
// and in phase 5 while memRead is high, the phase holds on every edge that
// samples mem_ready = 0 and advances on the first edge that samples 1. All
// outputs are combinational from the held state, so they stay constant for
// the whole stall. mem_ready is ignored in every other phase.
// -----------------------------------------------------------------------------
module seq_controller #(
    parameter int OPCODE_W    = 3,
    parameter int ALU_OP_W    = 2,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [2:0]          phase,
    output logic                addrSel,
    output logic                memRead,
    output logic                memWrite,
    output logic                loadIR,
    output logic                incPC,
    output logic                jump,
    output logic                ACCwrite,
    output logic                ALUToACC,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                dataEn,
    output logic                skip,
    output logic                Halt,
    output logic                illegal
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // State
    phase_e              phase_q, phase_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                halt_q, halt_d;

    // Decode of the latched opcode
    logic       op_legal;
    logic [2:0] op_lo;
    logic       dec_hlt, dec_skz, dec_add, dec_and, dec_xor, dec_lda, dec_sto, dec_jmp;
    logic       dec_aluop;
    logic       dec_alu_result;
    logic [1:0] alu_code;

    // Halt status and stall handling
    logic halt_now;
    logic halted;
    logic mem_ok;
    logic rd_w;

    // Any set bit above [2:0] makes the opcode illegal; the shift keeps this
    // valid for OPCODE_W = 3 where there are no upper bits at all.
    assign op_legal = ((op_q >> 3) == '0);
    assign op_lo    = op_q[2:0];

    // Illegal opcodes decode to nothing, so they run as a no-op.
    assign dec_hlt = op_legal && (op_lo == OP_HLT);
    assign dec_skz = op_legal && (op_lo == OP_SKZ);
    assign dec_add = op_legal && (op_lo == OP_ADD);
    assign dec_and = op_legal && (op_lo == OP_AND);
    assign dec_xor = op_legal && (op_lo == OP_XOR);
    assign dec_lda = op_legal && (op_lo == OP_LDA);
    assign dec_sto = op_legal && (op_lo == OP_STO);
    assign dec_jmp = op_legal && (op_lo == OP_JMP);

    // Instructions that read an operand and write the accumulator.
    assign dec_aluop      = dec_add | dec_and | dec_xor | dec_lda;
    // LDA loads memory data directly; the others take the ALU result.
    assign dec_alu_result = dec_add | dec_and | dec_xor;

    always_comb begin
        alu_code = 2'b00;
        if (dec_and) alu_code = 2'b01;
        if (dec_xor) alu_code = 2'b10;
        if (dec_lda) alu_code = 2'b11;
    end

    // Halt takes effect combinationally in the first phase-4 cycle of a HLT,
    // then the register keeps it set until reset.
    assign halt_now = (phase_q == PH_OP_ADDR) && dec_hlt;
    assign halted   = halt_q | halt_now;

    assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

    // Operand read in phases 5..7; also used to decide the phase-5 stall.
    assign rd_w = dec_aluop && !halted &&
                  ((phase_q == PH_OP_FETCH) || (phase_q == PH_ALU_OP) ||
                   (phase_q == PH_STORE));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        op_d    = op_q;
        halt_d  = halt_q | halt_now;

        if (!halted) begin
            case (phase_q)
                PH_INST_FETCH: begin
                    if (mem_ok) phase_d = PH_INST_LOAD;
                end
                PH_IDLE: begin
                    // Leaving phase 3 is the single point where the opcode
                    // is captured; phases 4..7 decode only this copy.
                    op_d    = opcode;
                    phase_d = PH_OP_ADDR;
                end
                PH_OP_FETCH: begin
                    if (!rd_w || mem_ok) phase_d = PH_ALU_OP;
                end
                PH_STORE: begin
                    phase_d = PH_INST_ADDR;
                end
                default: begin
                    phase_d = phase_e'(phase_q + 3'd1);
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_INST_ADDR;
            op_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            op_q    <= op_d;
            halt_q  <= halt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        phase    = phase_q;
        addrSel  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        loadIR   = 1'b0;
        incPC    = 1'b0;
        jump     = 1'b0;
        ACCwrite = 1'b0;
        ALUToACC = 1'b0;
        ALU_OP   = '0;
        dataEn   = 1'b0;
        skip     = 1'b0;
        Halt     = 1'b0;
        illegal  = 1'b0;

        if (halted) begin
            // Frozen in phase 4: only Halt is visible.
            Halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    addrSel = 1'b1;
                end
                PH_INST_FETCH: begin
                    addrSel = 1'b1;
                    memRead = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    addrSel = 1'b1;
                    memRead = 1'b1;
                    loadIR  = 1'b1;
                end
                PH_OP_ADDR: begin
                    incPC   = 1'b1;
                    illegal = !op_legal;
                end
                PH_OP_FETCH: begin
                    memRead     = rd_w;
                    ALU_OP[1:0] = alu_code;
                    illegal     = !op_legal;
                end
                PH_ALU_OP: begin
                    memRead     = rd_w;
                    ALU_OP[1:0] = alu_code;
                    incPC       = dec_skz & zero;
                    skip        = dec_skz & zero;
                    jump        = dec_jmp;
                    dataEn      = dec_sto;
                    illegal     = !op_legal;
                end
                PH_STORE: begin
                    memRead     = rd_w;
                    ALU_OP[1:0] = alu_code;
                    ACCwrite    = dec_aluop;
                    ALUToACC    = dec_alu_result;
                    jump        = dec_jmp;
                    memWrite    = dec_sto;
                    dataEn      = dec_sto;
                    illegal     = !op_legal;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_controller.sv
// -----------------------------------------------------------------------------
// Bench for seq_controller, instantiated with OPCODE_W = 4 so that illegal
// opcodes (bit 3 set) can be exercised alongside the legal set.
//
// Observation vector layout (17 bits):
//   [16:14] phase, 13 addrSel, 12 memRead, 11 memWrite, 10 loadIR, 9 incPC,
//   8 jump, 7 ACCwrite, 6 ALUToACC, [5:4] ALU_OP, 3 dataEn, 2 skip, 1 Halt,
//   0 illegal
// -----------------------------------------------------------------------------
module tb_seq_controller;

    localparam int OW = 4;
    localparam int AW = 2;
    localparam logic [16:0] RESET_VEC = 17'h02000;  // phase 0, addrSel only

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [OW-1:0] opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic [2:0]    phase;
    logic          addrSel, memRead, memWrite, loadIR, incPC, jump;
    logic          ACCwrite, ALUToACC, dataEn, skip, Halt, illegal;
    logic [AW-1:0] ALU_OP;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];

    seq_controller #(
        .OPCODE_W    (OW),
        .ALU_OP_W    (AW),
        .MEM_WAIT_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .phase     (phase),
        .addrSel   (addrSel),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .loadIR    (loadIR),
        .incPC     (incPC),
        .jump      (jump),
        .ACCwrite  (ACCwrite),
        .ALUToACC  (ALUToACC),
        .ALU_OP    (ALU_OP),
        .dataEn    (dataEn),
        .skip      (skip),
        .Halt      (Halt),
        .illegal   (illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Reset asserted just after an edge, released 2 time units after an
    // edge so the DUT sits in phase 0 until the following edge.
    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [16:0] dut_vec();
        return {phase, addrSel, memRead, memWrite, loadIR, incPC, jump,
                ACCwrite, ALUToACC, ALU_OP[1:0], dataEn, skip, Halt, illegal};
    endfunction

    // ---------------- reference model ----------------
    // Expected strobes for one cycle from the opcode map and phase table.
    function automatic logic [16:0] model(input int ph, input logic [3:0] op, input logic z);
        logic       legal, aluop, is_hlt, is_skz, is_sto, is_jmp, is_alu;
        logic       addr, rd, wr, ld, inc, jmp, accw, a2a, den, skp, hlt, ill;
        logic [1:0] alu;
        int         m;
        m      = int'(op[2:0]);
        legal  = (op[3] == 1'b0);
        is_hlt = legal && (m == 0);
        is_skz = legal && (m == 1);
        is_alu = legal && (m >= 2) && (m <= 4);
        aluop  = legal && (m >= 2) && (m <= 5);
        is_sto = legal && (m == 6);
        is_jmp = legal && (m == 7);
        {addr, rd, wr, ld, inc, jmp, accw, a2a, den, skp, hlt, ill} = '0;
        alu = 2'b00;
        if (ph >= 5 && aluop) alu = 2'(m - 2);
        if (ph >= 4) ill = !legal;
        case (ph)
            0: addr = 1'b1;
            1: begin addr = 1'b1; rd = 1'b1; end
            2, 3: begin addr = 1'b1; rd = 1'b1; ld = 1'b1; end
            4: begin
                if (is_hlt) hlt = 1'b1;
                else inc = 1'b1;
            end
            5: rd = aluop;
            6: begin
                rd  = aluop;
                inc = is_skz & z;
                skp = is_skz & z;
                jmp = is_jmp;
                den = is_sto;
            end
            default: begin
                rd   = aluop;
                accw = aluop;
                a2a  = is_alu;
                jmp  = is_jmp;
                wr   = is_sto;
                den  = is_sto;
            end
        endcase
        return {3'(ph), addr, rd, wr, ld, inc, jmp, accw, a2a, alu, den, skp, hlt, ill};
    endfunction

    // ---------------- driver + scoreboard ----------------
    // Runs one instruction from phase 0. s1/s5 are the number of mem_ready=0
    // cycles in phase 1 / phase 5. late_op < 0 randomises the opcode input in
    // phases 4..7. A legal HLT holds phase 4 for halt_hold cycles.
    task automatic run_instr(input string name, input logic [3:0] op, input logic z,
                             input int s1, input int s5, input int late_op,
                             input int halt_hold, output logic [16:0] p6,
                             output logic [16:0] p7, output int dut_len);
        int          plan[$];
        logic        legal, aluop;
        int          k1, k5, ph;
        logic        zc;
        logic [16:0] got, e;
        legal   = (op[3] == 1'b0);
        aluop   = legal && (op[2:0] >= 3'd2) && (op[2:0] <= 3'd5);
        p6      = '0;
        p7      = '0;
        dut_len = 0;
        plan.push_back(0);
        for (int i = 0; i <= s1; i++) plan.push_back(1);
        plan.push_back(2);
        plan.push_back(3);
        if (legal && op[2:0] == 3'd0) begin
            for (int i = 0; i < halt_hold; i++) plan.push_back(4);
        end else begin
            plan.push_back(4);
            for (int i = 0; i <= (aluop ? s5 : 0); i++) plan.push_back(5);
            plan.push_back(6);
            plan.push_back(7);
        end
        k1 = 0;
        k5 = 0;
        for (int i = 0; i < plan.size(); i++) begin
            ph = plan[i];
            if (ph <= 2) opcode = 4'($urandom_range(0, 15));
            else if (ph == 3) opcode = op;
            else opcode = (late_op < 0) ? 4'($urandom_range(0, 15)) : 4'(late_op);
            zc   = (ph == 6) ? z : 1'($urandom_range(0, 1));
            zero = zc;
            if (ph == 1) begin
                mem_ready = (k1 >= s1);
                k1++;
            end else if (ph == 5 && aluop) begin
                mem_ready = (k5 >= s5);
                k5++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            exp_q.push_back(model(ph, op, zc));
            @(negedge clk);
            got = dut_vec();
            e   = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s cyc%0d: got=%05h expected=%05h", name, i, got, e);
            end
            if (got[16:14] == 3'd6) p6 = got;
            if (got[16:14] == 3'd7) begin
                p7      = got;
                dut_len = i + 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [16:0] got;
        rst_n = 1'b0;
        @(negedge clk);
        got = dut_vec();
        total++;
        if (got !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_state: got=%05h expected=%05h", got, RESET_VEC);
        end
        apply_reset();
        // Abort an instruction mid-way: SKZ never stalls phase 5.
        opcode    = 4'b0001;
        mem_ready = 1'b1;
        zero      = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (phase !== 3'd5) begin
            bad++;
            $display("FAIL reset_pre_phase: got=%0d expected=5", phase);
        end
        #2 rst_n = 1'b0;
        #1 got = dut_vec();
        total++;
        if (got !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_abort: got=%05h expected=%05h", got, RESET_VEC);
        end
        apply_reset();
    endtask

    task automatic test_lda();
        logic [16:0] p6, p7;
        int          n;
        run_instr("lda", 4'b0101, 1'b0, 0, 0, -1, 0, p6, p7, n);
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL lda_len: got=%0d expected=8", n);
        end
        total++;
        if ({p7[7], p7[6], p7[5:4]} !== 4'b1011) begin
            bad++;
            $display("FAIL lda_p7: got=%b expected=1011", {p7[7], p7[6], p7[5:4]});
        end
        // Next instruction checks the wrap to phase 0 then phase 1.
        run_instr("after_lda", 4'b0100, 1'b0, 0, 0, -1, 0, p6, p7, n);
    endtask

    task automatic test_skz();
        logic [16:0] p6, p7;
        int          n;
        run_instr("skz_z1", 4'b0001, 1'b1, 0, 0, -1, 0, p6, p7, n);
        total++;
        if ({p6[9], p6[2]} !== 2'b11) begin
            bad++;
            $display("FAIL skz_taken: got=%b expected=11", {p6[9], p6[2]});
        end
        run_instr("skz_z0", 4'b0001, 1'b0, 0, 0, -1, 0, p6, p7, n);
        total++;
        if ({p6[9], p6[2]} !== 2'b00) begin
            bad++;
            $display("FAIL skz_not_taken: got=%b expected=00", {p6[9], p6[2]});
        end
    endtask

    task automatic test_stall();
        logic [16:0] p6, p7;
        int          n;
        run_instr("add_stall", 4'b0010, 1'b0, 3, 2, -1, 0, p6, p7, n);
        total++;
        if (n !== 13) begin
            bad++;
            $display("FAIL stall_len: got=%0d expected=13", n);
        end
        total++;
        if ({p7[7], p7[6], p7[5:4]} !== 4'b1100) begin
            bad++;
            $display("FAIL add_p7: got=%b expected=1100", {p7[7], p7[6], p7[5:4]});
        end
    endtask

    task automatic test_opcode_latch();
        logic [16:0] p6, p7;
        int          n;
        run_instr("sto_latch", 4'b0110, 1'b0, 1, 0, 7, 0, p6, p7, n);
        total++;
        if ({p7[11], p7[3], p7[8]} !== 3'b110) begin
            bad++;
            $display("FAIL sto_p7: got=%b expected=110", {p7[11], p7[3], p7[8]});
        end
    endtask

    task automatic test_halt();
        logic [16:0] p6, p7, got;
        int          n;
        run_instr("halt", 4'b0000, 1'b0, 1, 0, -1, 21, p6, p7, n);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 got = dut_vec();
        total++;
        if (got !== RESET_VEC) begin
            bad++;
            $display("FAIL halt_reset: got=%05h expected=%05h", got, RESET_VEC);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({phase, Halt} !== 4'b0010) begin
            bad++;
            $display("FAIL post_reset_phase: got=%0d/%0d expected=1/0", phase, Halt);
        end
        apply_reset();
    endtask

    task automatic test_illegal();
        logic [16:0] p6, p7;
        int          n;
        run_instr("illegal", 4'b1010, 1'b1, 1, 2, -1, 0, p6, p7, n);
        total++;
        if (p7[13:0] !== 14'h0001) begin
            bad++;
            $display("FAIL illegal_p7: got=%04h expected=0001", p7[13:0]);
        end
        run_instr("after_illegal", 4'b0101, 1'b0, 0, 1, -1, 0, p6, p7, n);
    endtask

    task automatic test_back_to_back();
        logic [16:0] p6, p7;
        int          n;
        logic [3:0]  op;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 15));
            if (op == 4'b0000) op = 4'b1000;
            run_instr("random", op, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3), -1, 0, p6, p7, n);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_skz();
        test_stall();
        test_opcode_latch();
        test_halt();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
